world_clock_ctrl: RTL and testbench

- Control and sequencing block for the world-clock hour datapath.
- Generates second and minute time-keeping, emits one-cycle hour_en pulses to the downstream 24-hour counter, and runs a button-driven set-mode FSM (hour / minute / time zone).
- Converts the counter's base (UTC) hour into the local hour for the selected zone.
- Downstream counter contract: it increments by exactly one on each cycle hour_en is high; its offset input is tied to 0.

---
 rtl/world_clock_pkg.sv | 29 ++
 rtl/world_clock_ctrl_btn_edge.sv | 22 ++
 rtl/world_clock_ctrl.sv | 132 +++++++++++++
 tb/tb_world_clock_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/world_clock_pkg.sv
// Shared types and constants for the world-clock control block.
// Zone offsets are whole hours east of UTC, stored modulo 24.
package world_clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2,
        SET_ZONE = 2'd3
    } mode_t;

    // UTC, CET, EET, MSK, IST, CST, JST, EST
    localparam logic [4:0] ZONE_OFFSET [8] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd5, 5'd8, 5'd9, 5'd19};

    localparam logic [5:0] SEC_MAX       = 6'd59;
    localparam logic [5:0] MIN_MAX       = 6'd59;
    localparam logic [5:0] HOURS_PER_DAY = 6'd24;
    localparam logic [4:0] BURST_LEN     = 5'd23;

    function automatic logic [4:0] to_local(input logic [4:0] base, input logic [2:0] zone);
        logic [5:0] sum;
        sum = {1'b0, base} + {1'b0, ZONE_OFFSET[zone]};
        if (sum >= HOURS_PER_DAY) begin
            sum = sum - HOURS_PER_DAY;
        end
        return sum[4:0];
    endfunction

endpackage

// File: rtl/world_clock_ctrl_btn_edge.sv
// Rising-edge detector for three pre-synchronised button levels; combinational press output.
// History resets to all-ones so a button held through reset never produces a press.
module btn_edge (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] level,
    output logic [2:0] press
);

    logic [2:0] prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev <= '1;
        end else begin
            prev <= level;
        end
    end

    assign press = level & ~prev;

endmodule

// File: rtl/world_clock_ctrl.sv
// Seconds/minutes timekeeping, set-mode FSM and hour_en sequencing for the world clock.
// Button presses act one cycle after sampling; hour_en is registered; no backpressure.
module world_clock_ctrl
    import world_clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 100,
    parameter int NUM_ZONES     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [4:0] base_hours,
    output logic       hour_en,
    output logic       busy,
    output logic [1:0] mode,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic [2:0] zone_sel,
    output logic [4:0] local_hours
);

    localparam int              PW         = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [2:0]      ZONE_LAST  = 3'(NUM_ZONES - 1);

    mode_t         state;
    logic [PW-1:0] presc;
    logic [4:0]    burst_cnt;
    logic [2:0]    press;
    logic          go_mode;
    logic          go_up;
    logic          go_down;
    logic          sec_tick;

    btn_edge u_btn_edge (
        .clk   (clk),
        .reset (reset),
        .level ({btn_down, btn_up, btn_mode}),
        .press (press)
    );

    // Mode beats up/down, up+down cancel, and a burst locks out every button.
    assign go_mode  = press[0] & ~busy;
    assign go_up    = press[1] & ~press[0] & ~press[2] & ~busy;
    assign go_down  = press[2] & ~press[0] & ~press[1] & ~busy;
    assign sec_tick = (state == RUN) && (presc == PRESC_LAST);

    assign mode        = state;
    assign local_hours = to_local(base_hours, zone_sel);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            presc     <= '0;
            sec       <= '0;
            min       <= '0;
            zone_sel  <= '0;
            hour_en   <= 1'b0;
            busy      <= 1'b0;
            burst_cnt <= '0;
        end else begin
            hour_en <= 1'b0;

            // Leaving RUN (or being outside it) parks the prescaler so RUN restarts a full second.
            if (state == RUN && !go_mode) begin
                presc <= sec_tick ? '0 : presc + 1'b1;
            end else begin
                presc <= '0;
            end

            if (sec_tick) begin
                if (sec == SEC_MAX) begin
                    sec <= '0;
                    if (min == MIN_MAX) begin
                        min     <= '0;
                        hour_en <= 1'b1;
                    end else begin
                        min <= min + 1'b1;
                    end
                end else begin
                    sec <= sec + 1'b1;
                end
            end

            if (busy) begin
                if (burst_cnt != '0) begin
                    hour_en   <= 1'b1;
                    burst_cnt <= burst_cnt - 1'b1;
                end else begin
                    busy <= 1'b0;
                end
            end

            case (state)
                SET_HOUR: begin
                    if (go_up) begin
                        hour_en <= 1'b1;
                    end else if (go_down) begin
                        // 23 increments on a mod-24 counter step it back by one hour.
                        busy      <= 1'b1;
                        hour_en   <= 1'b1;
                        burst_cnt <= BURST_LEN - 5'd1;
                    end
                end
                SET_MIN: begin
                    if (go_up) begin
                        min <= (min == MIN_MAX) ? '0 : min + 1'b1;
                        sec <= '0;
                    end else if (go_down) begin
                        min <= (min == '0) ? MIN_MAX : min - 1'b1;
                        sec <= '0;
                    end
                end
                SET_ZONE: begin
                    if (go_up) begin
                        zone_sel <= (zone_sel == ZONE_LAST) ? '0 : zone_sel + 1'b1;
                    end else if (go_down) begin
                        zone_sel <= (zone_sel == '0) ? ZONE_LAST : zone_sel - 1'b1;
                    end
                end
                default: ;
            endcase

            if (go_mode) begin
                state <= mode_t'(state + 2'd1);
            end
        end
    end

endmodule

// File: tb/tb_world_clock_ctrl.sv
// Randomised and directed scoreboard bench for world_clock_ctrl with TICKS_PER_SEC=4.
module tb_world_clock_ctrl;

    localparam int TPS = 4;
    localparam int NZ  = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [4:0] base_hours = 5'd0;
    logic       hour_en;
    logic       busy;
    logic [1:0] mode;
    logic [5:0] min;
    logic [5:0] sec;
    logic [2:0] zone_sel;
    logic [4:0] local_hours;

    always #5 clk = ~clk;

    world_clock_ctrl #(.TICKS_PER_SEC(TPS), .NUM_ZONES(NZ)) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_mode    (btn_mode),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .base_hours  (base_hours),
        .hour_en     (hour_en),
        .busy        (busy),
        .mode        (mode),
        .min         (min),
        .sec         (sec),
        .zone_sel    (zone_sel),
        .local_hours (local_hours)
    );

    typedef struct packed {
        logic [1:0] mode;
        logic [5:0] sec;
        logic [5:0] min;
        logic [2:0] zone;
        logic       he;
        logic       busy;
        logic [4:0] lh;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    int   seen_he  = 0;
    int   cyc_no   = 0;
    int   offs[8]  = '{0, 1, 2, 3, 5, 8, 9, 19};

    // Reference model: time as seconds-of-hour, burst as an age counter since the down press.
    int m_mode, m_sec, m_min, m_zone, m_ticks, m_age;
    bit m_pm, m_pu, m_pd;

    task automatic step(input bit r, input bit bm, input bit bu, input bit bd, input int base);
        exp_t e;
        bit   he, bz, pm, pu, pd, vm, vu, vd;
        int   t;
        reset      = r;
        btn_mode   = bm;
        btn_up     = bu;
        btn_down   = bd;
        base_hours = 5'(base);
        he = 1'b0;
        if (r) begin
            m_mode = 0; m_sec = 0; m_min = 0; m_zone = 0; m_ticks = 0; m_age = -1;
            m_pm = 1'b1; m_pu = 1'b1; m_pd = 1'b1;
        end else begin
            pm = bm && !m_pm; pu = bu && !m_pu; pd = bd && !m_pd;
            m_pm = bm; m_pu = bu; m_pd = bd;
            bz = (m_age >= 0);
            if (bz) begin
                m_age++;
                if (m_age == 23) m_age = -1;
            end
            vm = pm && !bz;
            vu = pu && !pm && !pd && !bz;
            vd = pd && !pm && !pu && !bz;
            if (m_mode == 0) begin
                m_ticks++;
                if (m_ticks == TPS) begin
                    m_ticks = 0;
                    t = m_min * 60 + m_sec + 1;
                    if (t == 3600) begin
                        t  = 0;
                        he = 1'b1;
                    end
                    m_min = t / 60;
                    m_sec = t % 60;
                end
            end
            case (m_mode)
                1: begin
                    if (vu) he = 1'b1;
                    else if (vd) m_age = 0;
                end
                2: begin
                    if (vu) begin m_min = (m_min + 1) % 60; m_sec = 0; end
                    else if (vd) begin m_min = (m_min + 59) % 60; m_sec = 0; end
                end
                3: begin
                    if (vu) m_zone = (m_zone + 1) % NZ;
                    else if (vd) m_zone = (m_zone + NZ - 1) % NZ;
                end
                default: ;
            endcase
            if (vm) m_mode = (m_mode + 1) % 4;
            if (m_mode != 0) m_ticks = 0;
        end
        e.mode = 2'(m_mode);
        e.sec  = 6'(m_sec);
        e.min  = 6'(m_min);
        e.zone = 3'(m_zone);
        e.busy = (m_age >= 0);
        e.he   = he || (m_age >= 0);
        e.lh   = 5'((base + offs[m_zone]) % 24);
        q.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, $urandom_range(0, 23));
    endtask

    task automatic press(input bit bm, input bit bu, input bit bd, input int base);
        step(1'b0, bm, bu, bd, base);
        step(1'b0, 1'b0, 1'b0, 1'b0, base);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        cyc_no++;
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            checks++;
            if (hour_en === 1'b1) seen_he++;
            if (mode !== mon_e.mode || sec !== mon_e.sec || min !== mon_e.min ||
                zone_sel !== mon_e.zone || hour_en !== mon_e.he || busy !== mon_e.busy ||
                local_hours !== mon_e.lh) begin
                failures++;
                $display("FAIL scoreboard cyc=%0d got mode=%0d sec=%0d min=%0d zone=%0d he=%0b busy=%0b lh=%0d exp mode=%0d sec=%0d min=%0d zone=%0d he=%0b busy=%0b lh=%0d",
                         cyc_no, mode, sec, min, zone_sel, hour_en, busy, local_hours,
                         mon_e.mode, mon_e.sec, mon_e.min, mon_e.zone, mon_e.he, mon_e.busy, mon_e.lh);
            end
        end
    end

    initial begin
        int s0;
        @(negedge clk);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 0);
        chk("reset_mode", mode, 0);
        chk("reset_hour_en", hour_en, 0);

        s0 = seen_he;
        idle(240);
        chk("run_240_min", min, 1);
        chk("run_240_sec", sec, 0);
        chk("run_240_no_pulse", seen_he - s0, 0);

        // Set 59 minutes, then let RUN carry into the hour.
        press(1, 0, 0, 0); press(1, 0, 0, 0);
        press(0, 0, 1, 0); press(0, 0, 1, 0);
        chk("set_min_59", min, 59);
        press(1, 0, 0, 0); press(1, 0, 0, 0);
        s0 = seen_he;
        idle(250);
        chk("carry_min", min, 0);
        chk("carry_pulses", seen_he - s0, 1);

        // SET_HOUR: up pulse, then down burst with presses attempted mid-burst.
        press(1, 0, 0, 0);
        s0 = seen_he;
        press(0, 1, 0, 0);
        chk("up_pulse", seen_he - s0, 1);
        press(0, 0, 1, 0);
        chk("burst_busy", busy, 1);
        idle(3);
        press(0, 1, 0, 0);
        idle(1);
        press(1, 0, 0, 0);
        idle(20);
        chk("burst_mode_kept", mode, 1);
        chk("burst_done", busy, 0);
        chk("burst_pulses", seen_he - s0, 24);

        // Back to RUN, wait for sec 37, then enter SET_MIN.
        press(1, 0, 0, 0); press(1, 0, 0, 0); press(1, 0, 0, 0);
        for (int k = 0; k < 400 && !(m_sec == 37 && m_ticks == 0); k++) idle(1);
        press(1, 0, 0, 0); press(1, 0, 0, 0);
        chk("setmin_sec_held", sec, 37);
        s0 = seen_he;
        press(0, 0, 1, 0);
        chk("setmin_down_wrap", min, 59);
        chk("setmin_sec_clr", sec, 0);
        chk("setmin_no_carry", seen_he - s0, 0);

        press(1, 1, 0, 0);
        chk("mode_wins_mode", mode, 3);
        chk("mode_wins_min", min, 59);

        for (int k = 0; k < 7; k++) press(0, 1, 0, 3);
        chk("zone_7", zone_sel, 7);
        chk("local_est", local_hours, 22);
        press(0, 1, 0, 3);
        chk("zone_wrap", zone_sel, 0);
        chk("local_utc", local_hours, 3);
        press(0, 1, 1, 3);
        chk("up_down_cancel", zone_sel, 0);

        // Randomised phase with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 499) == 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), $urandom_range(0, 23));
        end

        // Button held through reset must not fire later.
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, 5);
        step(1'b0, 1'b0, 1'b1, 1'b0, 5);
        s0 = seen_he;
        step(1'b0, 1'b1, 1'b1, 1'b0, 5);
        step(1'b0, 1'b0, 1'b1, 1'b0, 5);
        chk("held_up_mode", mode, 1);
        chk("held_up_no_pulse", seen_he - s0, 0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 5);
        step(1'b0, 1'b0, 1'b0, 1'b1, 5);
        idle(4);
        step(1'b1, 1'b0, 1'b0, 1'b0, 5);
        chk("abort_hour_en", hour_en, 0);
        chk("abort_busy", busy, 0);
        chk("abort_mode", mode, 0);
        idle(10);

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
